// File: rtl/hazard_issue_ctrl.sv
// In-order issue controller: buffers up to 8 instruction bytes, then issues them with RAW stall bubbles.
// Optional macro HAZARD_FORWARDING_EN: only lw-use at distance 1 stalls; otherwise writers at distance 1 and 2 stall.
module hazard_issue_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_instr,
  output logic       in_ready,
  input  logic       start,
  output logic       issue_valid,
  output logic [7:0] issue_instr,
  output logic       issue_bubble,
  input  logic       issue_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] stall_count
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic       wvalid;
    logic [2:0] wreg;
    logic       is_lw;
  } sb_entry_t;

  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] stall_q, stall_d;
  sb_entry_t  age1_q, age1_d;
  sb_entry_t  age2_q, age2_d;
  logic [7:0] buf_q [8];
  logic [7:0] buf_d [8];

  logic [7:0] cur_instr;
  logic [1:0] opc;
  logic [2:0] fa, fb;
  logic       rd_fa, rd_fb, wr_fa, cur_lw;
  logic       hazard;
  logic       load_acc;

  function automatic logic reads_match(input sb_entry_t e, input logic rfa, input logic rfb,
                                       input logic [2:0] ra, input logic [2:0] rb);
    return e.wvalid && ((rfa && (e.wreg == ra)) || (rfb && (e.wreg == rb)));
  endfunction

  always_comb begin
    cur_instr = buf_q[ptr_q];
    opc       = cur_instr[7:6];
    fa        = cur_instr[5:3];
    fb        = cur_instr[2:0];
    rd_fa     = (opc == 2'b01) || (opc == 2'b10);
    rd_fb     = (opc != 2'b00);
    wr_fa     = (opc == 2'b11) || (opc == 2'b01);
    cur_lw    = (opc == 2'b11);
`ifdef HAZARD_FORWARDING_EN
    // ALU results forward; only a load one slot back cannot be bypassed.
    hazard = age1_q.is_lw && reads_match(age1_q, rd_fa, rd_fb, fa, fb);
`else
    hazard = reads_match(age1_q, rd_fa, rd_fb, fa, fb) ||
             reads_match(age2_q, rd_fa, rd_fb, fa, fb);
`endif
  end

  always_comb begin
    in_ready     = (state_q == ST_LOAD) && (count_q < 4'd8);
    issue_valid  = (state_q == ST_ISSUE);
    issue_bubble = issue_valid && hazard;
    issue_instr  = (issue_valid && !hazard) ? cur_instr : 8'h00;
    busy         = (state_q == ST_ISSUE);
    done         = (state_q == ST_DONE);
    stall_count  = stall_q;
    load_acc     = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    age1_d  = age1_q;
    age2_d  = age2_q;
    buf_d   = buf_q;
    case (state_q)
      ST_LOAD: begin
        if (load_acc) begin
          buf_d[count_q[2:0]] = in_instr;
          count_d             = count_q + 4'd1;
        end
        // A start in the same cycle as the first accept still counts as a non-empty program.
        if ((count_d == 4'd8) || (start && (count_d != 4'd0))) begin
          state_d = ST_ISSUE;
          ptr_d   = 3'd0;
          stall_d = 8'd0;
          age1_d  = '0;
          age2_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (issue_ready) begin
          age2_d = age1_q;
          if (hazard) begin
            age1_d = '0;
            if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
          end else begin
            age1_d = '{wvalid: wr_fa, wreg: fa, is_lw: cur_lw};
            ptr_d  = ptr_q + 3'd1;
            if ({1'b0, ptr_q} == (count_q - 4'd1)) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_LOAD;
        count_d = 4'd0;
      end
      default: begin
        state_d = ST_LOAD;
        count_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      count_q <= 4'd0;
      ptr_q   <= 3'd0;
      stall_q <= 8'd0;
      age1_q  <= '0;
      age2_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      age1_q  <= age1_d;
      age2_q  <= age2_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Self-checking bench for hazard_issue_ctrl: directed programs plus random programs against a history-based model.
module tb_hazard_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_instr;
  logic       in_ready;
  logic       start;
  logic       issue_valid;
  logic [7:0] issue_instr;
  logic       issue_bubble;
  logic       issue_ready;
  logic       busy;
  logic       done;
  logic [7:0] stall_count;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];
  int         hist_w[$];
  bit         hist_lw[$];
  int         model_stalls;

  always #5 clk = ~clk;

  hazard_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .start(start),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_bubble(issue_bubble),
    .issue_ready(issue_ready),
    .busy(busy), .done(done), .stall_count(stall_count)
  );

  // Hazard from the distance to earlier accepted slots (-1 = slot wrote nothing).
  function automatic bit model_hazard(input logic [7:0] ins);
    int op  = int'(ins[7:6]);
    int ra  = int'(ins[5:3]);
    int rb  = int'(ins[2:0]);
    bit rfa = (op == 1) || (op == 2);
    bit rfb = (op != 0);
    bit hz  = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      if (hist_w.size() >= k) begin
        int w = hist_w[hist_w.size() - k];
        bit l = hist_lw[hist_lw.size() - k];
        bit m = (w >= 0) && ((rfa && w == ra) || (rfb && w == rb));
`ifdef HAZARD_FORWARDING_EN
        if (k == 1 && l && m) hz = 1'b1;
`else
        if (m) hz = 1'b1;
`endif
      end
    end
    return hz;
  endfunction

  task automatic apply_reset;
    rst = 1'b1; in_valid = 1'b0; in_instr = 8'h00; start = 1'b0; issue_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_program(input logic [7:0] prog [8], input int n, input int rdy_pct);
    int ptr = 0;
    int cyc = 0;
    bit fin = 1'b0;
    bit hz;
    bit rdy;
    logic [7:0] exp_i;
    got_q.delete(); hist_w.delete(); hist_lw.delete(); model_stalls = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL load_in_ready byte %0d got %b want 1", i, in_ready);
      end
      in_valid = 1'b1; in_instr = prog[i]; start = (i == n - 1) && (n < 8);
    end
    @(negedge clk);
    start = 1'b0;
    if (n == 8) begin in_valid = 1'b1; in_instr = 8'hFF; end
    else in_valid = 1'b0;
    while (!fin && cyc < 300) begin
      hz    = model_hazard(prog[ptr]);
      exp_i = hz ? 8'h00 : prog[ptr];
      checks++;
      if (issue_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL issue_ctl got v=%b busy=%b rdy=%b done=%b want 1 1 0 0",
                           issue_valid, busy, in_ready, done);
      end
      checks++;
      if (issue_instr !== exp_i || issue_bubble !== hz) begin
        errors++; $display("FAIL issue_slot ptr %0d got %h/%b want %h/%b",
                           ptr, issue_instr, issue_bubble, exp_i, hz);
      end
      checks++;
      if (stall_count !== 8'(model_stalls)) begin
        errors++; $display("FAIL issue_stalls got %0d want %0d", stall_count, model_stalls);
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      issue_ready = rdy;
      if (rdy) begin
        got_q.push_back({hz, exp_i});
        if (hz) begin
          hist_w.push_back(-1); hist_lw.push_back(1'b0);
          if (model_stalls < 255) model_stalls++;
        end else begin
          hist_w.push_back((prog[ptr][7:6] == 2'b11 || prog[ptr][7:6] == 2'b01) ? int'(prog[ptr][5:3]) : -1);
          hist_lw.push_back(prog[ptr][7:6] == 2'b11);
          ptr++;
          if (ptr == n) fin = 1'b1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    issue_ready = 1'b0; in_valid = 1'b0;
    if (!fin) begin
      errors++; $display("FAIL issue_timeout got ptr %0d want %0d", ptr, n);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || issue_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL done_pulse got done=%b busy=%b v=%b rdy=%b want 1 0 0 0",
                         done, busy, issue_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || stall_count !== 8'(model_stalls)) begin
      errors++; $display("FAIL after_done got done=%b rdy=%b stalls=%0d want 0 1 %0d",
                         done, in_ready, stall_count, model_stalls);
    end
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (in_ready !== 1'b1 || issue_valid !== 1'b0 || issue_instr !== 8'h00 || issue_bubble !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || stall_count !== 8'h00) begin
      errors++; $display("FAIL reset_values got rdy=%b v=%b i=%h b=%b busy=%b done=%b st=%0d",
                         in_ready, issue_valid, issue_instr, issue_bubble, busy, done, stall_count);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL empty_start got busy=%b rdy=%b want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_directed(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int n, input logic [8:0] exp_s[$], input int exp_st, input string nm);
    logic [7:0] p [8] = '{b0, b1, b2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit ok;
    run_program(p, n, 100);
    ok = (got_q.size() == exp_s.size());
    if (ok) foreach (exp_s[i]) if (got_q[i] !== exp_s[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_seq got %p want %p", nm, got_q, exp_s);
    end
    checks++;
    if (stall_count !== 8'(exp_st)) begin
      errors++; $display("FAIL %s_stalls got %0d want %0d", nm, stall_count, exp_st);
    end
  endtask

  task automatic test_dependencies;
    logic [8:0] e[$];
`ifdef HAZARD_FORWARDING_EN
    e = {9'h04A, 9'h059};
    test_directed(8'h4A, 8'h59, 8'h00, 2, e, 0, "add_add");
    e = {9'h0D0, 9'h100, 9'h062};
    test_directed(8'hD0, 8'h62, 8'h00, 2, e, 1, "load_use");
    e = {9'h04A, 9'h000, 9'h059};
    test_directed(8'h4A, 8'h00, 8'h59, 3, e, 0, "noop_gap");
`else
    e = {9'h04A, 9'h100, 9'h100, 9'h059};
    test_directed(8'h4A, 8'h59, 8'h00, 2, e, 2, "add_add");
    e = {9'h0D0, 9'h100, 9'h100, 9'h062};
    test_directed(8'hD0, 8'h62, 8'h00, 2, e, 2, "load_use");
    e = {9'h04A, 9'h000, 9'h100, 9'h059};
    test_directed(8'h4A, 8'h00, 8'h59, 3, e, 1, "noop_gap");
`endif
  endtask

  task automatic test_full_buffer;
    logic [7:0] p [8] = '{8'h4A, 8'h8A, 8'h59, 8'hD3, 8'h9B, 8'h00, 8'h6C, 8'h41};
    run_program(p, 8, 80);
  endtask

  task automatic test_stall_hold_and_reset;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 8'hD0;
    @(negedge clk);
    in_instr = 8'h62; start = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    checks++;
    if (issue_instr !== 8'hD0 || issue_bubble !== 1'b0) begin
      errors++; $display("FAIL hold_first got %h/%b want d0/0", issue_instr, issue_bubble);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (issue_instr !== 8'h00 || issue_bubble !== 1'b1 || stall_count !== 8'd0) begin
        errors++; $display("FAIL hold_stable cyc %0d got %h/%b st=%0d want 00/1 st=0",
                           i, issue_instr, issue_bubble, stall_count);
      end
      if (i < 5) @(negedge clk);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    checks++;
    if (stall_count !== 8'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_accept got st=%0d busy=%b want 1 1", stall_count, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || issue_valid !== 1'b0 || issue_instr !== 8'h00 || issue_bubble !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || stall_count !== 8'h00) begin
      errors++; $display("FAIL mid_reset got rdy=%b v=%b i=%h b=%b busy=%b done=%b st=%0d",
                         in_ready, issue_valid, issue_instr, issue_bubble, busy, done, stall_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] p [8];
    int n;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++)
        p[i] = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      run_program(p, n, 60);
    end
  endtask

  initial begin
    test_reset();
    test_dependencies();
    test_full_buffer();
    test_stall_hold_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
